// File: rtl/divctrl_pkg.sv
// rtl/divctrl_pkg.sv - shared types and defaults for the divided-clock controller
package divctrl_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int DW_DEFAULT  = 26;
    // Widest half-period count any build may use; shadow records are sized to it
    localparam int DW_MAX      = 32;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_PEND
    } ch_state_t;

    typedef struct packed {
        logic [DW_MAX-1:0] div;
        logic              en;
    } cfg_t;

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one glitch-free toggle divider with deferred reconfiguration
module div_channel
    import divctrl_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sync,
    input  logic          acc,
    input  logic [DW-1:0] acc_div,
    input  logic          acc_en,
    output logic          clk_out,
    output logic          tick,
    output logic          active,
    output logic          pending
);

    ch_state_t         state, state_n;
    logic [DW-1:0]     cnt, cnt_n;
    logic [DW_MAX-1:0] cur_div, cur_div_n;
    cfg_t              shadow, shadow_n;
    logic              clk_n, tick_n;
    logic              term;

    // Terminal count of the half-period currently running
    assign term    = (DW_MAX'(cnt) == cur_div);
    assign active  = (state != CH_IDLE);
    assign pending = (state == CH_PEND);

    // State, counter, divisor, shadow and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CH_IDLE;
            cnt     <= '0;
            cur_div <= '0;
            shadow  <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cur_div <= cur_div_n;
            shadow  <= shadow_n;
            clk_out <= clk_n;
            tick    <= tick_n;
        end
    end

    // Next-state: start from idle, count, and apply shadowed updates only at terminal count
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cur_div_n = cur_div;
        shadow_n  = shadow;
        clk_n     = clk_out;
        tick_n    = 1'b0;
        case (state)
            CH_IDLE: begin
                if (acc && acc_en) begin
                    cur_div_n = DW_MAX'(acc_div);
                    cnt_n     = '0;
                    state_n   = CH_RUN;
                end
            end
            CH_RUN, CH_PEND: begin
                if (sync) begin
                    // Realignment beats a coincident terminal count; updates stay queued
                    cnt_n = '0;
                    clk_n = 1'b0;
                end else if (term) begin
                    clk_n  = ~clk_out;
                    tick_n = 1'b1;
                    cnt_n  = '0;
                    if (state == CH_PEND) begin
                        if (shadow.en) begin
                            cur_div_n = shadow.div;
                            state_n   = CH_RUN;
                        end else if (clk_out) begin
                            // Stop only on the falling toggle so the last high phase is full
                            state_n = CH_IDLE;
                        end
                    end
                end else begin
                    cnt_n = cnt + DW'(1);
                end
                // An update accepted on a terminal edge waits for the following one
                if (acc && state == CH_RUN) begin
                    shadow_n.div = DW_MAX'(acc_div);
                    shadow_n.en  = acc_en;
                    state_n      = CH_PEND;
                end
            end
            default: state_n = CH_IDLE;
        endcase
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - multi-channel divider bank with config decode (optional DIVCTRL_SYNC_EN)
module clk_div_ctrl
    import divctrl_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int DW  = DW_DEFAULT,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
`ifdef DIVCTRL_SYNC_EN
    input  logic           sync,
`endif
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_chan,
    input  logic [DW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] active,
    output logic [NCH-1:0] pending
);

    logic           sync_int;
    logic [NCH-1:0] acc;

`ifdef DIVCTRL_SYNC_EN
    assign sync_int = sync;
`else
    assign sync_int = 1'b0;
`endif

    // Ready mirrors the target channel's pending flag; out-of-range channels always accept
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_chan == CW'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign acc[g] = cfg_valid && cfg_ready && (cfg_chan == CW'(g));

        div_channel #(
            .DW (DW)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .sync    (sync_int),
            .acc     (acc[g]),
            .acc_div (cfg_div),
            .acc_en  (cfg_en),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .active  (active[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Multi-channel divided-clock controller: owns a bank of NCH toggle dividers and sequences their configuration. A single valid/ready config port programs each channel's half-period count and enable. Updates to running channels take effect only at a terminal count, so every divided output stays glitch-free. It sits between the board-level clock and the slow consumers (LED blinkers, scan timers, debouncers) that need divided clocks or tick strobes.

## Interface
- NCH, 4: number of divider channels (1..8)
- DW, 26: width of the half-period count
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- cfg_valid  input  1  config request valid
- cfg_ready  output  1  config request may be accepted; equals ~pending[cfg_chan], combinational
- cfg_chan  input  $clog2(NCH)  target channel; values ≥ NCH are accepted and ignored
- cfg_div  input  DW  half-period count; output half-period = cfg_div+1 cycles
- cfg_en  input  1  1 = run channel, 0 = stop channel
- clk_out  output  NCH  divided clock per channel, registered
- tick  output  NCH  one-cycle strobe on every clk_out toggle, registered
- active  output  NCH  channel running
- pending  output  NCH  accepted config not yet applied

## Operation
- Per-channel state: CH_IDLE, CH_RUN, CH_PEND.
- A request is accepted on a clk edge with cfg_valid && cfg_ready.
- CH_IDLE, cfg_en=1: load div, clear counter, go to CH_RUN immediately.
- CH_IDLE, cfg_en=0: no effect; pending stays 0.
- CH_RUN: store {div, en} in a shadow register and go to CH_PEND.
- Counter (CH_RUN/CH_PEND): on counter==div, toggle clk_out, pulse tick, and clear the counter; otherwise increment.
- Output period = 2*(div+1) cycles. div=0 gives clk/2.
- In CH_PEND, the pending update applies at a terminal count:
  - shadow en=1: clk_out toggles as normal, the shadow div is loaded, the counter clears, and the state goes to CH_RUN.
  - shadow en=0, clk_out currently 1: clk_out toggles to 0, tick pulses, the counter clears, and the state goes to CH_IDLE.
  - shadow en=0, clk_out currently 0: normal toggle to 1; the channel stays CH_PEND and stops at the next terminal count.
- Acceptance on the same edge as that channel's terminal count: the terminal count uses the old div, and the request applies at the following terminal count.
- While pending[ch]=1, further requests to ch stall because cfg_ready is low. Other channels remain independent.
- Widths: counter is DW bits and never exceeds div. No wrap-around is possible.

## Timing
- Reset values: clk_out=0, tick=0, active=0, pending=0, all counters 0, all shadows cleared, all channels CH_IDLE.
- Reset mid-operation drops pending updates and forces clk_out low on the next edge.
- From CH_IDLE, accept at edge T: active=1 after T. First toggle (clk_out 0→1, tick=1) is visible after edge T+div+1.
- pending rises the cycle after acceptance. It falls in the same cycle the update's clk_out change and tick appear.
- Worst-case apply latency after acceptance: one half-period for an enable/div update; two half-periods for a stop.
- active falls together with clk_out's final 1→0 transition.

## Configuration
- DIVCTRL_SYNC_EN defined: adds input sync (1 bit).
  - A sync pulse clears the counters of all CH_RUN/CH_PEND channels and forces their clk_out to 0, with no tick.
  - Pending updates stay pending.
  - sync coincident with a terminal count wins: no toggle occurs.
  - sync coincident with acceptance: the acceptance proceeds normally.
- DIVCTRL_SYNC_EN undefined: no sync port; channels free-run from their own start edge.

## Structure
- Package divctrl_pkg holds:
  - NCH_DEFAULT, DW_DEFAULT
  - the ch_state_t enum {CH_IDLE, CH_RUN, CH_PEND}
  - the packed cfg_t {div, en} shadow record.
- One sub-module, div_channel, contains the counter, clk_out/tick registers, shadow register and state machine. It is instantiated NCH times in a generate loop.
- Top level contains request decode, cfg_ready muxing and the optional sync fan-out.

## Test plan
- Reset, then enable ch0 with div=3 → active[0] next cycle; clk_out[0] toggles every 4 cycles (period 8); tick[0] pulses coincide with each toggle.
- ch1 running with div=9; write div=1 mid-half-period → pending[1]=1 and cfg_ready=0 for cfg_chan=1. The remaining half-period stays 10 cycles, then half-periods become 2; pending falls at that toggle.
- ch2 running with div=4; write en=0 while clk_out[2]=0 → one more rising toggle, then stop on the falling toggle. clk_out[2]=0, active[2]=0, no further ticks.
- Write to ch3 on the exact terminal-count edge, changing div=2→5 → that toggle keeps the old period; the next half-period is 3 cycles, then 6.
- Assert reset while ch0 is CH_PEND with clk_out=1 → all outputs 0 on the next edge; the pending update is discarded and the channel stays idle.
- With DIVCTRL_SYNC_EN: ch0 div=2 and ch1 div=5 out of phase; pulse sync → both outputs go low; the next toggles occur 3 and 6 cycles later respectively.
